// File: rtl/mmult_arbiter_if.sv
// Client and engine bus of the shared 3x3 matrix-multiply arbiter.
// Latency: n/a (signal bundle only).
// Backpressure: req is held by a client until its ack pulse.
interface mmult_arbiter_if;
    logic [1:0]   req;
    logic [71:0]  a0_mat;
    logic [71:0]  b0_mat;
    logic [71:0]  a1_mat;
    logic [71:0]  b1_mat;
    logic [1:0]   ack;
    logic [1:0]   done;
    logic [1:0]   err;
    logic [152:0] c_mat;
    logic         busy;
    logic         eng_clr;
    logic         eng_en;
    logic [71:0]  eng_a;
    logic [71:0]  eng_b;
    logic         eng_valid;
    logic [152:0] eng_c;

    // Arbiter side: takes client requests and engine results, drives the rest.
    modport slave (
        input  req, a0_mat, b0_mat, a1_mat, b1_mat, eng_valid, eng_c,
        output ack, done, err, c_mat, busy, eng_clr, eng_en, eng_a, eng_b
    );

    // Environment side: clients plus the engine.
    modport master (
        output req, a0_mat, b0_mat, a1_mat, b1_mat, eng_valid, eng_c,
        input  ack, done, err, c_mat, busy, eng_clr, eng_en, eng_a, eng_b
    );
endinterface

// File: rtl/mmult_arbiter.sv
// Round-robin sharing of one 3x3 mmult engine between two requesters.
// Latency: ack at T, engine enabled from T+2, done at T+2+N (N = engine cycles, or TIMEOUT).
// Backpressure: one job at a time; other requests wait in IDLE until the owner's done.
module mmult_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic           clk,
    input  logic           reset,
    mmult_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           owner;
    logic           rr;
    logic           err_flag;
    logic [CNT_W-1:0] cnt;
    logic [71:0]    eng_a_q;
    logic [71:0]    eng_b_q;
    logic [152:0]   c_mat_q;

    logic           grant_vld;
    logic           grant_id;
    logic           timeout_hit;
    logic [1:0]     ack_c;
    logic [1:0]     done_c;
    logic [1:0]     err_c;

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // Grant selection: only in IDLE; on a tie the requester that did not own the last job wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (!reset && state == IDLE) begin
            case (bus.req)
                2'b01:   begin grant_vld = 1'b1; grant_id = 1'b0; end
                2'b10:   begin grant_vld = 1'b1; grant_id = 1'b1; end
                2'b11:   begin grant_vld = 1'b1; grant_id = ~rr;  end
                default: begin grant_vld = 1'b0; grant_id = 1'b0; end
            endcase
        end
    end

    // Next-state logic; a valid result takes precedence over a coincident timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_vld) state_nxt = LOAD;
            LOAD: state_nxt = RUN;
            RUN:  if (bus.eng_valid || timeout_hit) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pulse outputs; reset forces them quiet even if the state register is still mid-job.
    always_comb begin
        ack_c  = 2'b00;
        done_c = 2'b00;
        err_c  = 2'b00;
        if (grant_vld) ack_c[grant_id] = 1'b1;
        if (!reset && state == DONE) begin
            done_c[owner] = 1'b1;
            err_c[owner]  = err_flag;
        end
    end

    // State, operand latch, run counter and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rr       <= 1'b0;
            err_flag <= 1'b0;
            cnt      <= '0;
            eng_a_q  <= '0;
            eng_b_q  <= '0;
            c_mat_q  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_vld) begin
                owner   <= grant_id;
                eng_a_q <= grant_id ? bus.a1_mat : bus.a0_mat;
                eng_b_q <= grant_id ? bus.b1_mat : bus.b0_mat;
            end
            case (state)
                LOAD: cnt <= '0;
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (bus.eng_valid) begin
                        c_mat_q  <= bus.eng_c;
                        err_flag <= 1'b0;
                    end else if (timeout_hit) begin
                        c_mat_q  <= '0;
                        err_flag <= 1'b1;
                    end
                end
                DONE: rr <= owner;
                default: ;
            endcase
        end
    end

    assign bus.ack     = ack_c;
    assign bus.done    = done_c;
    assign bus.err     = err_c;
    assign bus.c_mat   = c_mat_q;
    assign bus.busy    = !reset && (state != IDLE);
    assign bus.eng_clr = reset || (state == LOAD);
    assign bus.eng_en  = !reset && (state == RUN);
    assign bus.eng_a   = eng_a_q;
    assign bus.eng_b   = eng_b_q;

endmodule

// File: tb/tb_mmult_arbiter.sv
// Directed bench for mmult_arbiter with a behavioural 3x3 engine of programmable latency.
// Latency: engine asserts valid on its lat-th enabled cycle (lat = 0 never asserts).
// Backpressure: clients hold req until ack, then drop it.
module tb_mmult_arbiter;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   lat = 0;
    int   ecnt = 0;
    logic [152:0] eng_c_m;

    mmult_arbiter_if bus();

    mmult_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: counts enabled cycles since the last clear.
    always @(posedge clk) begin
        if (bus.eng_clr)     ecnt <= 0;
        else if (bus.eng_en) ecnt <= ecnt + 1;
    end

    assign bus.eng_valid = bus.eng_en && (lat != 0) && (ecnt == lat - 1);

    // Engine product, truncated to the 17-bit element width.
    always_comb begin
        eng_c_m = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int acc;
                acc = 0;
                for (int k = 0; k < 3; k++)
                    acc += int'(bus.eng_a[r*24+k*8 +: 8]) * int'(bus.eng_b[k*24+c*8 +: 8]);
                eng_c_m[r*51+c*17 +: 17] = 17'(acc);
            end
        end
    end

    assign bus.eng_c = eng_c_m;

    function automatic logic [71:0] m8(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
        int e [9];
        logic [71:0] m;
        e = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
        m = '0;
        for (int i = 0; i < 9; i++) m[i*8 +: 8] = 8'(e[i]);
        return m;
    endfunction

    function automatic logic [152:0] c17(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
        int e [9];
        logic [152:0] m;
        e = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
        m = '0;
        for (int i = 0; i < 9; i++) m[i*17 +: 17] = 17'(e[i]);
        return m;
    endfunction

    task automatic chk(input string name, input logic [152:0] act, input logic [152:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_ack(input string name, output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ack != 2'b00) begin at = cyc; break; end
        end
        if (at < 0) begin
            n_chk++;
            $display("FAIL %s: no ack within 40 cycles", name);
        end
    endtask

    task automatic wait_done(input string name, output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done != 2'b00) begin at = cyc; break; end
        end
        if (at < 0) begin
            n_chk++;
            $display("FAIL %s: no done within 40 cycles", name);
        end
    endtask

    task automatic edge_drive();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]   req;
        logic [71:0]  a;
        logic [71:0]  b;
        int           lat;
        logic [1:0]   exp_ack;
        logic [152:0] exp_c;
        logic         exp_err;
    } vec_t;

    vec_t vt [5];

    initial begin
        logic [71:0]  I8, SEQ8, ALL2, ALL3, ALL5, ALL255;
        logic [152:0] C_SEQ, C_2SEQ, C_255;
        int ta, td, ndone;
        logic [1:0] exp_g [4];

        I8     = m8(1, 0, 0, 0, 1, 0, 0, 0, 1);
        SEQ8   = m8(1, 2, 3, 4, 5, 6, 7, 8, 9);
        ALL2   = m8(2, 2, 2, 2, 2, 2, 2, 2, 2);
        ALL3   = m8(3, 3, 3, 3, 3, 3, 3, 3, 3);
        ALL5   = m8(5, 5, 5, 5, 5, 5, 5, 5, 5);
        ALL255 = m8(255, 255, 255, 255, 255, 255, 255, 255, 255);
        C_SEQ  = c17(1, 2, 3, 4, 5, 6, 7, 8, 9);
        C_2SEQ = c17(24, 30, 36, 24, 30, 36, 24, 30, 36);
        // 255*255*3 = 195075 wraps in a 17-bit element to 64003.
        C_255  = c17(195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075);

        //          req    A       B      lat  ack    C        err
        vt[0] = '{2'b01, I8,    SEQ8,   3,  2'b01, C_SEQ,  1'b0};
        vt[1] = '{2'b10, ALL2,  SEQ8,   5,  2'b10, C_2SEQ, 1'b0};
        vt[2] = '{2'b01, ALL255, ALL255, 1, 2'b01, C_255,  1'b0};
        vt[3] = '{2'b10, SEQ8,  I8,    TIMEOUT, 2'b10, C_SEQ, 1'b0};
        vt[4] = '{2'b01, I8,    SEQ8,   0,  2'b01, '0,     1'b1};

        reset = 1'b1;
        bus.req = 2'b00;
        bus.a0_mat = '0; bus.b0_mat = '0; bus.a1_mat = '0; bus.b1_mat = '0;

        // Reset state.
        @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 153'(bus.ack), 153'(2'b00));
        chk("rst_done_err", 153'({bus.done, bus.err}), 153'(4'b0000));
        chk("rst_busy_en", 153'({bus.busy, bus.eng_en}), 153'(2'b00));
        chk("rst_eng_clr", 153'(bus.eng_clr), 153'(1'b1));
        chk("rst_c_mat", bus.c_mat, 153'(0));
        chk("rst_eng_ab", 153'({bus.eng_a, bus.eng_b}), 153'(0));
        edge_drive();
        reset = 1'b0;
        @(negedge clk);
        chk("idle_eng_clr", 153'(bus.eng_clr), 153'(1'b0));

        // Table of single-requester jobs.
        for (int i = 0; i < 5; i++) begin
            edge_drive();
            lat = vt[i].lat;
            bus.a0_mat = vt[i].req[0] ? vt[i].a : ALL3;
            bus.b0_mat = vt[i].req[0] ? vt[i].b : ALL3;
            bus.a1_mat = vt[i].req[1] ? vt[i].a : ALL3;
            bus.b1_mat = vt[i].req[1] ? vt[i].b : ALL3;
            bus.req = vt[i].req;
            wait_ack($sformatf("v%0d_ack_wait", i), ta);
            chk($sformatf("v%0d_ack", i), 153'(bus.ack), 153'(vt[i].exp_ack));
            edge_drive();
            bus.req = 2'b00;
            bus.a0_mat = ALL5; bus.b0_mat = ALL5; bus.a1_mat = ALL5; bus.b1_mat = ALL5;
            @(negedge clk);
            chk($sformatf("v%0d_load_clr_en", i), 153'({bus.eng_clr, bus.eng_en}), 153'(2'b10));
            wait_done($sformatf("v%0d_done_wait", i), td);
            chk($sformatf("v%0d_latency", i), 153'(td - ta),
                153'((vt[i].lat == 0 ? TIMEOUT : vt[i].lat) + 2));
            chk($sformatf("v%0d_done", i), 153'(bus.done), 153'(vt[i].exp_ack));
            chk($sformatf("v%0d_err", i), 153'(bus.err), 153'(vt[i].exp_err ? vt[i].exp_ack : 2'b00));
            chk($sformatf("v%0d_c_mat", i), bus.c_mat, vt[i].exp_c);
            @(negedge clk);
            chk($sformatf("v%0d_busy_after", i), 153'({bus.busy, bus.done}), 153'(3'b000));
        end

        // Simultaneous requests straight after reset: requester 1 first.
        edge_drive();
        reset = 1'b1;
        edge_drive();
        reset = 1'b0;
        lat = 2;
        bus.a0_mat = ALL255; bus.b0_mat = ALL255;
        bus.a1_mat = I8;     bus.b1_mat = SEQ8;
        bus.req = 2'b11;
        wait_ack("sim_ack_wait", ta);
        chk("sim_first_ack", 153'(bus.ack), 153'(2'b10));
        edge_drive();
        bus.req = 2'b01;
        wait_done("sim_done1_wait", td);
        chk("sim_done1", 153'({bus.done, bus.ack}), 153'(4'b1000));
        chk("sim_c1", bus.c_mat, C_SEQ);
        @(negedge clk);
        chk("sim_second_ack", 153'({bus.ack, bus.busy}), 153'(3'b010));
        chk("sim_c1_held", bus.c_mat, C_SEQ);
        edge_drive();
        bus.req = 2'b00;
        wait_done("sim_done0_wait", td);
        chk("sim_done0", 153'(bus.done), 153'(2'b01));
        chk("sim_c0", bus.c_mat, C_255);

        // Fairness: both requesters hold req across four jobs.
        exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
        lat = 1;
        edge_drive();
        bus.req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wait_ack($sformatf("fair%0d_wait", j), ta);
            chk($sformatf("fair%0d_grant", j), 153'(bus.ack), 153'(exp_g[j]));
        end
        edge_drive();
        bus.req = 2'b00;
        wait_done("fair_last_wait", td);
        chk("fair_last_done", 153'(bus.done), 153'(2'b01));

        // Reset during the second RUN cycle aborts the job silently.
        edge_drive();
        lat = 10;
        bus.a0_mat = I8; bus.b0_mat = SEQ8;
        bus.req = 2'b01;
        wait_ack("mid_ack_wait", ta);
        edge_drive();
        bus.req = 2'b00;
        edge_drive();
        edge_drive();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_clr_en_done", 153'({bus.eng_clr, bus.eng_en, bus.done}), 153'(4'b1000));
        edge_drive();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 153'(bus.busy), 153'(1'b0));
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done != 2'b00) ndone++;
        end
        chk("mid_rst_no_done", 153'(ndone), 153'(0));
        edge_drive();
        lat = 3;
        bus.a1_mat = ALL2; bus.b1_mat = SEQ8;
        bus.req = 2'b10;
        wait_ack("post_rst_ack_wait", ta);
        chk("post_rst_ack", 153'(bus.ack), 153'(2'b10));
        edge_drive();
        bus.req = 2'b00;
        wait_done("post_rst_done_wait", td);
        chk("post_rst_done", 153'({bus.done, bus.err}), 153'(4'b1000));
        chk("post_rst_c", bus.c_mat, C_2SEQ);
        chk("post_rst_latency", 153'(td - ta), 153'(5));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
